// File: rtl/ps2_host_rx.sv
// Host-side PS/2 receiver: conditions the line pair, deserialises 11-bit frames,
// checks start/parity/stop and queues good bytes in a small FIFO with valid/ready drain.
module ps2_host_rx #(
  parameter int FILTER    = 4,
  parameter int TIMEOUT   = 1024,
  parameter int FIFO_BITS = 2
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int                 DEPTH    = 1 << FIFO_BITS;
  localparam logic [FIFO_BITS:0] DEPTH_C  = (FIFO_BITS + 1)'(DEPTH);
  localparam logic [3:0]         FLT_LAST = 4'(FILTER - 1);
  localparam logic [15:0]        TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]           clk_sync;
  logic [1:0]           dat_sync;
  logic                 fclk;
  logic [3:0]           flt_cnt;
  logic                 fall;
  logic                 dat_bit;

  logic [3:0]           bit_cnt;
  logic [7:0]           shreg;
  logic                 par_acc;
  logic                 perr_flag;
  logic [15:0]          tmo_cnt;
  logic                 tmo_hit;

  logic [7:0]           mem [DEPTH];
  logic [FIFO_BITS-1:0] wr_ptr;
  logic [FIFO_BITS-1:0] rd_ptr;
  logic [FIFO_BITS:0]   count;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 wr_en;

  // A fall is the edge on which the filtered clock is about to drop to 0.
  assign fall    = fclk && !clk_sync[1] && (flt_cnt == FLT_LAST);
  assign dat_bit = dat_sync[1];

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      fclk     <= 1'b1;
      flt_cnt  <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      if (clk_sync[1] != fclk) begin
        if (flt_cnt == FLT_LAST) begin
          fclk    <= clk_sync[1];
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + 4'd1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign tmo_hit = !fall && (bit_cnt != 4'd0) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      perr_flag  <= 1'b0;
      tmo_cnt    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) tmo_cnt <= '0;
      else if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;

      if (fall) begin
        if (bit_cnt == 4'd0) begin
          if (dat_bit) begin
            frame_err <= 1'b1;
          end else begin
            bit_cnt   <= 4'd1;
            par_acc   <= 1'b0;
            perr_flag <= 1'b0;
          end
        end else if (bit_cnt <= 4'd8) begin
          shreg   <= {dat_bit, shreg[7:1]};
          par_acc <= par_acc ^ dat_bit;
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          perr_flag <= ~(par_acc ^ dat_bit);
          bit_cnt   <= 4'd10;
        end else begin
          bit_cnt <= '0;
          if (!dat_bit)       frame_err  <= 1'b1;
          else if (perr_flag) parity_err <= 1'b1;
        end
      end else if (tmo_hit) begin
        bit_cnt   <= '0;
        perr_flag <= 1'b0;
        frame_err <= 1'b1;
      end
    end
  end

  // Good stop bit with clean parity: the assembled byte is offered to the FIFO.
  assign push  = fall && (bit_cnt == 4'd10) && dat_bit && !perr_flag;
  assign full  = (count == DEPTH_C);
  assign pop   = (count != '0) && rx_ready;
  assign wr_en = push && (!full || pop);

  // NOTE: the storage array carries no reset; only pointers and count define
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rx_valid = (count != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

endmodule
